// File: rtl/dm_responder_if.sv
// Data-memory port bundle between a core (master) and dm_responder (slave).
// Carries byte-enabled write, every-cycle read address, clear request and status.
interface dm_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [3:0]            dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_writedata;
    logic                  clear_i;
    logic [DATA_WIDTH-1:0] dm_readdata;
    logic                  busy_o;

    modport master (
        output dm_we, dm_addr, dm_writedata, clear_i,
        input  dm_readdata, busy_o
    );

    modport slave (
        input  dm_we, dm_addr, dm_writedata, clear_i,
        output dm_readdata, busy_o
    );
endinterface

// File: rtl/dm_responder.sv
// Word-addressed data memory with byte-enabled writes and a zeroing sequencer.
// Latency: READ_LATENCY (1..3) cycles address-to-data; DM_WRITE_FIRST_EN selects same-address write-first bypass.
// Backpressure: none; full throughput except during clear, where host writes are dropped and reads return 0.
module dm_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    dm_responder_if.slave dm
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_nxt;
    logic                  in_clear;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [3:0]            wr_be;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [DATA_WIDTH-1:0] rd_s1_nxt;
    logic [DATA_WIDTH-1:0] pipe_q [READ_LATENCY];

    assign in_clear = (state_q == ST_CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_nxt;
            clr_cnt_q <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        clr_cnt_nxt = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (dm.clear_i) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            ST_CLEAR: begin
                // Counter wraps to 0 on the last word, ready for the next request.
                clr_cnt_nxt = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // The sequencer owns the write port while clearing; host writes are dropped.
    always_comb begin
        if (in_clear) begin
            wr_be   = 4'hF;
            wr_addr = clr_cnt_q;
            wr_dat  = '0;
        end else begin
            wr_be   = dm.dm_we;
            wr_addr = dm.dm_addr;
            wr_dat  = dm.dm_writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_dat[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_s1_nxt = mem[dm.dm_addr];
`ifdef DM_WRITE_FIRST_EN
        for (int i = 0; i < 4; i++) begin
            if (dm.dm_we[i]) begin
                rd_s1_nxt[8*i +: 8] = dm.dm_writedata[8*i +: 8];
            end
        end
`endif
        if (in_clear) begin
            rd_s1_nxt = '0;
        end
    end

    // Stage 0 is the registered array read; later stages are plain delay registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= rd_s1_nxt;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dm.dm_readdata = pipe_q[READ_LATENCY-1];

    // Held low while rst is asserted so an aborted clear is visible immediately.
    assign dm.busy_o = in_clear & ~rst;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: latency-1 and latency-2 instances share stimulus; reads are scoreboarded.
module tb_dm_responder;

`ifdef DM_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    logic clk;
    logic rst;

    dm_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dm1 ();
    dm_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dm2 ();

    dm_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
    ) u_dut_l1 (
        .clk(clk), .rst(rst), .dm(dm1)
    );

    dm_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
    ) u_dut_l2 (
        .clk(clk), .rst(rst), .dm(dm2)
    );

    typedef struct {
        logic [31:0] dat;
        bit          chk;
        int          tag;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1;
    exp_t e2;

    int       n_chk;
    int       n_fail;
    bit       in_rst;
    bit       m_clear;
    bit [7:0] m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard drain: one entry per edge, popped once the instance's latency has elapsed.
    always begin
        @(posedge clk);
        #1;
        if (!in_rst) begin
            if (q1.size() >= 1) begin
                e1 = q1.pop_front();
                if (e1.chk) begin
                    n_chk++;
                    if (dm1.dm_readdata !== e1.dat) begin
                        n_fail++;
                        $display("FAIL rd_lat1 tag=%0d got=%h exp=%h", e1.tag, dm1.dm_readdata, e1.dat);
                    end
                end
            end
            if (q2.size() >= 2) begin
                e2 = q2.pop_front();
                if (e2.chk) begin
                    n_chk++;
                    if (dm2.dm_readdata !== e2.dat) begin
                        n_fail++;
                        $display("FAIL rd_lat2 tag=%0d got=%h exp=%h", e2.tag, dm2.dm_readdata, e2.dat);
                    end
                end
            end
            n_chk++;
            if (dm1.busy_o !== m_clear || dm2.busy_o !== m_clear) begin
                n_fail++;
                $display("FAIL busy_track got=%b/%b exp=%b", dm1.busy_o, dm2.busy_o, m_clear);
            end
        end
    end

    // One clock cycle of stimulus, entered and left at the falling edge.
    task automatic cyc(input logic [3:0] we, input logic [7:0] a, input logic [31:0] wd,
                       input logic clr, input bit chk, input logic [31:0] ex, input int tag);
        exp_t e;
        dm1.dm_we = we; dm1.dm_addr = a; dm1.dm_writedata = wd; dm1.clear_i = clr;
        dm2.dm_we = we; dm2.dm_addr = a; dm2.dm_writedata = wd; dm2.clear_i = clr;
        e.dat = ex;
        e.chk = chk;
        e.tag = tag;
        q1.push_back(e);
        q2.push_back(e);
        @(posedge clk);
        if (m_clear) begin
            if (m_cnt == 8'd255) m_clear = 1'b0;
            m_cnt = m_cnt + 8'd1;
        end else if (clr) begin
            m_clear = 1'b1;
            m_cnt   = 8'd0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(4'h0, 8'd0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] ex, input int tag);
        cyc(4'h0, a, 32'h0, 1'b0, 1'b1, ex, tag);
    endtask

    task automatic wr(input logic [3:0] we, input logic [7:0] a, input logic [31:0] wd);
        cyc(we, a, wd, 1'b0, 1'b0, 32'h0, 0);
    endtask

    task automatic drive_idle();
        dm1.dm_we = 4'h0; dm1.dm_addr = 8'd0; dm1.dm_writedata = 32'h0; dm1.clear_i = 1'b0;
        dm2.dm_we = 4'h0; dm2.dm_addr = 8'd0; dm2.dm_writedata = 32'h0; dm2.clear_i = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        rst    = 1'b1;
        in_rst = 1'b1;
        q1.delete();
        q2.delete();
        drive_idle();
        #1;
        n_chk++;
        if (dm1.busy_o !== 1'b0 || dm2.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_async got=%b/%b exp=0", nm, dm1.busy_o, dm2.busy_o);
        end
        n_chk++;
        if (dm1.dm_readdata !== 32'h0 || dm2.dm_readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL %s_rd_async got=%h/%h exp=0", nm, dm1.dm_readdata, dm2.dm_readdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        m_clear = 1'b1;
        m_cnt   = 8'd0;
        in_rst  = 1'b0;
        #1;
        n_chk++;
        if (dm1.busy_o !== 1'b1 || dm2.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy_release got=%b/%b exp=1", nm, dm1.busy_o, dm2.busy_o);
        end
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (dm1.busy_o === 1'b1 && n < 300) begin
            idle(1);
            n++;
        end
        n_chk++;
        if (n != 256) begin
            n_fail++;
            $display("FAIL %s_busy_len got=%0d exp=256", nm, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        n_chk++;
        if (dm1.busy_o !== 1'b0 || dm2.busy_o !== 1'b0 ||
            dm1.dm_readdata !== 32'h0 || dm2.dm_readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL por_state got busy=%b/%b rd=%h/%h exp 0", dm1.busy_o, dm2.busy_o,
                     dm1.dm_readdata, dm2.dm_readdata);
        end
        rst = 1'b0; m_clear = 1'b1; m_cnt = 8'd0; in_rst = 1'b0;
        #1;
        n_chk++;
        if (dm1.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL por_busy_release got=%b exp=1", dm1.busy_o);
        end
        count_busy("por");
        for (int a = 0; a < 256; a++) wr(4'hF, 8'(a), 32'hFFFF_FFFF);
        rd(8'd0,   32'hFFFF_FFFF, 1);
        rd(8'd128, 32'hFFFF_FFFF, 2);
        do_reset("rst_pre");
        count_busy("rst_pre");
        rd(8'd0,   32'h0, 3);
        rd(8'd128, 32'h0, 4);
        rd(8'd255, 32'h0, 5);
        idle(2);
    endtask

    task automatic test_byte_write();
        wr(4'hF, 8'd4, 32'h4444_4444);
        wr(4'hF, 8'd6, 32'h6666_6666);
        wr(4'hF, 8'd5, 32'hAABB_CCDD);
        wr(4'b0010, 8'd5, 32'h0000_1100);
        cyc(4'h0, 8'd6, 32'h0, 1'b0, 1'b1, 32'h6666_6666, 10);
        rd(8'd5, 32'hAABB_11DD, 11);
        rd(8'd4, 32'h4444_4444, 12);
        rd(8'd6, 32'h6666_6666, 13);
        idle(2);
    endtask

    task automatic test_pipeline();
        wr(4'hF, 8'd1, 32'h11);
        wr(4'hF, 8'd2, 32'h22);
        wr(4'hF, 8'd3, 32'h33);
        rd(8'd1, 32'h11, 20);
        rd(8'd2, 32'h22, 21);
        rd(8'd3, 32'h33, 22);
        idle(2);
    endtask

    task automatic test_same_cycle();
        wr(4'hF, 8'd9, 32'h1234_5678);
        cyc(4'hF, 8'd9, 32'hCAFE_BABE, 1'b0, 1'b1, WF ? 32'hCAFE_BABE : 32'h1234_5678, 30);
        rd(8'd9, 32'hCAFE_BABE, 31);
        wr(4'hF, 8'd10, 32'h1122_3344);
        cyc(4'b0101, 8'd10, 32'hAABB_CCDD, 1'b0, 1'b1, WF ? 32'h11BB_33DD : 32'h1122_3344, 32);
        rd(8'd10, 32'h11BB_33DD, 33);
        idle(2);
    endtask

    task automatic test_back_to_back();
        // Addresses 40..47 were zeroed by the preceding clear.
        for (int i = 0; i < 8; i++)
            cyc(4'hF, 8'(40 + i), 32'hA000_0000 | i, 1'b0, 1'b1, WF ? (32'hA000_0000 | i) : 32'h0, 40 + i);
        for (int i = 7; i >= 0; i--)
            rd(8'(40 + i), 32'hA000_0000 | i, 50 + i);
        for (int i = 0; i < 4; i++) begin
            wr(4'hF, 8'(60 + i), 32'hB000_0000 | i);
            rd(8'(40 + i), 32'hA000_0000 | i, 60 + i);
        end
        for (int i = 0; i < 4; i++) rd(8'(60 + i), 32'hB000_0000 | i, 70 + i);
        idle(2);
    endtask

    task automatic test_clear_drop();
        int n;
        cyc(4'hF, 8'd8, 32'h7777_7777, 1'b1, 1'b0, 32'h0, 0);
        n = 0;
        while (dm1.busy_o === 1'b1 && n < 300) begin
            if (n == 3) rd(8'd9, 32'h0, 80);
            else if (n == 200) wr(4'hF, 8'd7, 32'h5);
            else if (n == 50 || n == 254 || n == 255) cyc(4'h0, 8'd0, 32'h0, 1'b1, 1'b0, 32'h0, 0);
            else idle(1);
            n++;
        end
        n_chk++;
        if (n != 256) begin
            n_fail++;
            $display("FAIL clr_busy_len got=%0d exp=256", n);
        end
        rd(8'd7, 32'h0, 81);
        rd(8'd8, 32'h0, 82);
        rd(8'd9, 32'h0, 83);
        idle(2);
    endtask

    task automatic test_reset_mid_clear();
        wr(4'hF, 8'd200, 32'hDEAD_BEEF);
        cyc(4'h0, 8'd0, 32'h0, 1'b1, 1'b0, 32'h0, 0);
        idle(100);
        n_chk++;
        if (dm1.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy_before got=%b exp=1", dm1.busy_o);
        end
        do_reset("mid");
        count_busy("mid");
        rd(8'd200, 32'h0, 90);
        rd(8'd0,   32'h0, 91);
        idle(2);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        m_clear = 1'b0;
        m_cnt   = 8'd0;
        test_reset();
        test_byte_write();
        test_pipeline();
        test_same_cycle();
        test_back_to_back();
        test_clear_drop();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
